// File: rtl/ws2811_if.sv
// Colour-fetch and serial-line bundle between ws2811_driver (master) and its
// neighbours: ledcontroller supplies colour, the system supplies enable.
interface ws2811_if;
  logic       enable;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic [7:0] ledindex;
  logic       data_out;
  logic       busy;
  logic       frame_done;

  modport master (
    input  enable, red, green, blue,
    output ledindex, data_out, busy, frame_done
  );

  modport slave (
    output enable, red, green, blue,
    input  ledindex, data_out, busy, frame_done
  );
endinterface

// File: rtl/ws2811_driver.sv
// WS2811 serial output stage: walks ledindex over the strip, prefetches each
// LED's colour and shifts it out MSB first, with a latch gap between frames.
module ws2811_driver #(
  parameter int NUM_LEDS     = 50,
  parameter int BIT_CYCLES   = 60,
  parameter int T0H_CYCLES   = 17,
  parameter int T1H_CYCLES   = 34,
  parameter int RESET_CYCLES = 3000
) (
  input  logic     clk,
  input  logic     reset_n,
  ws2811_if.master bus
);

  localparam int CYC_W = $clog2(BIT_CYCLES);
  localparam int GAP_W = $clog2(RESET_CYCLES);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] T0H_C    = CYC_W'(T0H_CYCLES);
  localparam logic [CYC_W-1:0] T1H_C    = CYC_W'(T1H_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RESET_CYCLES - 1);
  localparam logic [7:0]       LED_LAST = 8'(NUM_LEDS - 1);
  localparam logic [8:0]       LEDS_9   = 9'(NUM_LEDS);

  typedef enum logic {LATCH, SHIFT} state_t;

  state_t           state, state_nx;
  logic [GAP_W-1:0] gap_cnt, gap_nx;
  logic [CYC_W-1:0] cyc_cnt, cyc_nx;
  logic [4:0]       bit_idx, bit_nx;
  logic [23:0]      sreg, sreg_nx;
  logic [7:0]       cur_led, led_nx;
  logic [7:0]       ledindex_r, idx_nx;
  logic             dout_r, dout_nx;
  logic             done_r, done_nx;
  logic             fetch_nx;
  logic [8:0]       nxt2;
  logic             vld_p0, vld_p1;
  logic [23:0]      pix_p2;

  function automatic logic bit_level(input logic [CYC_W-1:0] cyc, input logic b);
    return b ? (cyc < T1H_C) : (cyc < T0H_C);
  endfunction

  always_comb begin
    state_nx = state;
    gap_nx   = gap_cnt;
    cyc_nx   = cyc_cnt;
    bit_nx   = bit_idx;
    sreg_nx  = sreg;
    led_nx   = cur_led;
    idx_nx   = ledindex_r;
    dout_nx  = dout_r;
    done_nx  = 1'b0;
    fetch_nx = 1'b0;
    nxt2     = {1'b0, cur_led} + 9'd2;
    case (state)
      LATCH: begin
        dout_nx = 1'b0;
        idx_nx  = 8'd0;
        if (gap_cnt == GAP_LAST) begin
          // Counter saturates here until enable allows the next frame.
          if (bus.enable) begin
            state_nx = SHIFT;
            gap_nx   = '0;
            cyc_nx   = '0;
            bit_nx   = '0;
            sreg_nx  = pix_p2;
            led_nx   = 8'd0;
            dout_nx  = 1'b1;
            if (NUM_LEDS > 1) begin
              idx_nx   = 8'd1;
              fetch_nx = 1'b1;
            end
          end
        end else begin
          gap_nx = gap_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (cyc_cnt != CYC_LAST) begin
          cyc_nx  = cyc_cnt + 1'b1;
          dout_nx = bit_level(cyc_cnt + 1'b1, sreg[23]);
        end else begin
          cyc_nx = '0;
          if (bit_idx != 5'd23) begin
            bit_nx  = bit_idx + 1'b1;
            sreg_nx = {sreg[22:0], 1'b0};
            dout_nx = 1'b1;
          end else if (cur_led != LED_LAST) begin
            // Reload the prefetched LED and start fetching the one after it.
            bit_nx  = '0;
            sreg_nx = pix_p2;
            led_nx  = cur_led + 1'b1;
            dout_nx = 1'b1;
            if (nxt2 < LEDS_9) begin
              idx_nx   = nxt2[7:0];
              fetch_nx = 1'b1;
            end
          end else begin
            state_nx = LATCH;
            gap_nx   = '0;
            bit_nx   = '0;
            idx_nx   = 8'd0;
            dout_nx  = 1'b0;
            done_nx  = 1'b1;
            fetch_nx = 1'b1;
          end
        end
      end
      default: state_nx = LATCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= LATCH;
      gap_cnt    <= '0;
      cyc_cnt    <= '0;
      bit_idx    <= '0;
      sreg       <= '0;
      cur_led    <= '0;
      ledindex_r <= '0;
      dout_r     <= 1'b0;
      done_r     <= 1'b0;
      vld_p0     <= 1'b1;
      vld_p1     <= 1'b0;
      pix_p2     <= '0;
    end else begin
      state      <= state_nx;
      gap_cnt    <= gap_nx;
      cyc_cnt    <= cyc_nx;
      bit_idx    <= bit_nx;
      sreg       <= sreg_nx;
      cur_led    <= led_nx;
      ledindex_r <= idx_nx;
      dout_r     <= dout_nx;
      done_r     <= done_nx;
      // p0: ledindex changed; p1: ledcontroller registered it; p2: capture.
      vld_p0     <= fetch_nx;
      vld_p1     <= vld_p0;
      if (vld_p1) pix_p2 <= {bus.red, bus.green, bus.blue};
    end
  end

  assign bus.ledindex   = ledindex_r;
  assign bus.data_out   = dout_r;
  assign bus.busy       = (state == SHIFT);
  assign bus.frame_done = done_r;

endmodule
